fb_write_scheduler: RTL and testbench

//  Sequences each frame's writes into the back buffer of the double frame buffer and shares the single write port.
//  Per frame it optionally clears the back buffer, then round-robin arbitrates two render requesters (0 = world/blocks, 1 = overlay/UI).

---
 rtl/fb_write_scheduler.sv | 147 ++++++++++++++
 tb/tb_fb_write_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_scheduler
// Description : Per-frame writer for the back buffer. It optionally clears the
//               buffer, then arbitrates two requesters round-robin onto the one
//               write port, and asks for the buffer swap at frame end.
//               Optional clear pass is built when FB_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_scheduler #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                PIXELS      = 64000,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = 8'h00
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              frame_start,
    input  logic              frame_complete,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_done,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_done,
    output logic              req1_ready,
    output logic              wren,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] frame_buffer_data,
    output logic              switch_buffer,
    output logic              busy,
    output logic              swap_done
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CLEAR     = 2'd1,
        S_RENDER    = 2'd2,
        S_WAIT_SWAP = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] c_pixels = (ADDR_W+1)'(PIXELS);

    state_t            r_state;
    logic              r_last_grant;   // 1 = req1 was granted most recently
    logic              r_done0;
    logic              r_done1;
`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(PIXELS - 1);
    logic [ADDR_W-1:0] r_clr_addr;
`endif

    logic              w_grant;
    logic              w_xfer;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Contended cycles go to whoever was not served last; a lone requester always wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_xfer     = (r_state == S_RENDER) && (req0_valid || req1_valid);
    assign req0_ready = w_xfer && !w_grant;
    assign req1_ready = w_xfer && w_grant;
    assign w_addr     = w_grant ? req1_addr : req0_addr;
    assign w_data     = w_grant ? req1_data : req0_data;
    assign w_in_range = {1'b0, w_addr} < c_pixels;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state           <= S_IDLE;
            r_last_grant      <= 1'b1;     // so req0 wins the first contended cycle
            r_done0           <= 1'b0;
            r_done1           <= 1'b0;
            wren              <= 1'b0;
            write_addr        <= '0;
            frame_buffer_data <= '0;
            switch_buffer     <= 1'b0;
            swap_done         <= 1'b0;
`ifdef FB_CLEAR_EN
            r_clr_addr        <= '0;
`endif
        end else begin
            wren      <= 1'b0;
            swap_done <= 1'b0;
            if (req0_done) r_done0 <= 1'b1;
            if (req1_done) r_done1 <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_done0 <= 1'b0;
                        r_done1 <= 1'b0;
`ifdef FB_CLEAR_EN
                        r_clr_addr <= '0;
                        r_state    <= S_CLEAR;
`else
                        r_state    <= S_RENDER;
`endif
                    end
                end
`ifdef FB_CLEAR_EN
                S_CLEAR: begin
                    wren              <= 1'b1;
                    write_addr        <= r_clr_addr;
                    frame_buffer_data <= CLEAR_COLOR;
                    r_clr_addr        <= r_clr_addr + 1'b1;
                    if (r_clr_addr == c_last_addr) r_state <= S_RENDER;
                end
`endif
                S_RENDER: begin
                    if (w_xfer) begin
                        wren              <= w_in_range;
                        write_addr        <= w_addr;
                        frame_buffer_data <= w_data;
                        r_last_grant      <= w_grant;
                    end else if (r_done0 && r_done1) begin
                        // Only reached on an idle cycle, so the last write has already left.
                        switch_buffer <= 1'b1;
                        r_state       <= S_WAIT_SWAP;
                    end
                end
                S_WAIT_SWAP: begin
                    if (frame_complete) begin
                        switch_buffer <= 1'b0;
                        swap_done     <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_write_scheduler
// Description : Randomised scoreboard bench for fb_write_scheduler (PIXELS=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_scheduler;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int PIXELS = 16;
`ifdef FB_CLEAR_EN
    localparam int CLEAR_CYCLES = PIXELS;
`else
    localparam int CLEAR_CYCLES = 0;
`endif

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              frame_start = 1'b0;
    logic              frame_complete = 1'b0;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_done = 1'b0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_done = 1'b0;
    logic              req1_ready;
    logic              wren;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] frame_buffer_data;
    logic              switch_buffer;
    logic              busy;
    logic              swap_done;

    fb_write_scheduler #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .PIXELS     (PIXELS),
        .CLEAR_COLOR(8'h00)
    ) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .frame_start      (frame_start),
        .frame_complete   (frame_complete),
        .req0_valid       (req0_valid),
        .req0_addr        (req0_addr),
        .req0_data        (req0_data),
        .req0_done        (req0_done),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_addr        (req1_addr),
        .req1_data        (req1_data),
        .req1_done        (req1_done),
        .req1_ready       (req1_ready),
        .wren             (wren),
        .write_addr       (write_addr),
        .frame_buffer_data(frame_buffer_data),
        .switch_buffer    (switch_buffer),
        .busy             (busy),
        .swap_done        (swap_done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model: frame phase, who was served last, done flags.
    bit  m_last1;
    int  m_clear_left;
    bit  m_render;
    bit  m_wait;
    bit  m_done0;
    bit  m_done1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last1      = 1'b1;
        m_clear_left = 0;
        m_render     = 1'b0;
        m_wait       = 1'b0;
        m_done0      = 1'b0;
        m_done1      = 1'b0;
    endtask

    // Monitor: every write the DUT presents must be the next expected one.
    always @(negedge CLK) begin
        wr_t e;
        if (RESET_N === 1'b1 && wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", write_addr, frame_buffer_data);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(write_addr), 32'(e.a));
                check("write_data", 32'(frame_buffer_data), 32'(e.d));
            end
        end
    end

    task automatic step(input logic fs, input logic v0, input logic [ADDR_W-1:0] a0,
                        input logic [DATA_W-1:0] d0, input logic v1,
                        input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                        input logic dn0, input logic dn1, input logic fc);
        logic e0, e1, pick1;
        wr_t  w;
        @(negedge CLK);
        frame_start = fs;  frame_complete = fc;
        req0_valid = v0;   req0_addr = a0;  req0_data = d0;  req0_done = dn0;
        req1_valid = v1;   req1_addr = a1;  req1_data = d1;  req1_done = dn1;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (m_render) begin
            if (v0 || v1) begin
                pick1   = (v0 && v1) ? !m_last1 : v1;
                m_last1 = pick1;
                e0      = !pick1;
                e1      = pick1;
                w.a     = pick1 ? a1 : a0;
                w.d     = pick1 ? d1 : d0;
                if (int'(w.a) < PIXELS) exp_q.push_back(w);
            end else if (m_done0 && m_done1) begin
                m_render = 1'b0;
                m_wait   = 1'b1;
            end
        end else if (m_wait) begin
            if (fc) m_wait = 1'b0;
        end else if (fs) begin
            m_done0      = 1'b0;
            m_done1      = 1'b0;
            m_clear_left = CLEAR_CYCLES;
            m_render     = 1'b1;
            for (int i = 0; i < CLEAR_CYCLES; i++) begin
                w.a = ADDR_W'(i);
                w.d = 8'h00;
                exp_q.push_back(w);
            end
        end
        check("req0_ready", 32'(req0_ready), 32'(e0));
        check("req1_ready", 32'(req1_ready), 32'(e1));
        if (dn0) m_done0 = 1'b1;
        if (dn1) m_done1 = 1'b1;
    endtask

    task automatic idle_step(input logic fc);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, fc);
    endtask

    task automatic rand_step(input logic fs, input logic force_v0);
        step(fs, force_v0 | 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 19)),
             DATA_W'($urandom), 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 19)),
             DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_wren"},   32'(wren), 0);
        check({name, "_addr"},   32'(write_addr), 0);
        check({name, "_data"},   32'(frame_buffer_data), 0);
        check({name, "_switch"}, 32'(switch_buffer), 0);
        check({name, "_busy"},   32'(busy), 0);
        check({name, "_swap"},   32'(swap_done), 0);
    endtask

    task automatic run_frame(input int nrand, input bit rr_fresh);
        rand_step(1'b1, 1'b0);
        repeat (CLEAR_CYCLES) rand_step(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, ADDR_W'($urandom_range(0, PIXELS-1)), DATA_W'($urandom),
                 1'b1, ADDR_W'($urandom_range(0, PIXELS-1)), DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
            if (rr_fresh) check("rr_sequence", 32'(req1_ready), 32'(i % 2));
        end
        step(1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(PIXELS), 8'hAA, 1'b0, 1'b0, 1'b0);
        repeat (nrand) rand_step(1'b0, 1'b0);
        step(1'b0, 1'b1, ADDR_W'($urandom_range(0, PIXELS-1)), DATA_W'($urandom),
             1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        idle_step(1'b0);
        idle_step(1'b0);
        check("switch_rises", 32'(switch_buffer), 1);
        check("final_write_drained", 32'(exp_q.size()), 0);
        repeat (10) begin
            idle_step(1'b0);
            check("switch_held", 32'(switch_buffer), 1);
            check("busy_waiting", 32'(busy), 1);
        end
        idle_step(1'b1);
        idle_step(1'b0);
        check("swap_switch_low", 32'(switch_buffer), 0);
        check("swap_done_pulse", 32'(swap_done), 1);
        check("swap_busy_low", 32'(busy), 0);
        idle_step(1'b0);
        check("swap_done_once", 32'(swap_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            frame_start = 1'($urandom);  frame_complete = 1'($urandom);
            req0_valid = 1'($urandom);   req0_addr = ADDR_W'($urandom);  req0_done = 1'($urandom);
            req1_valid = 1'($urandom);   req1_addr = ADDR_W'($urandom);  req1_done = 1'($urandom);
            #1;
            check_quiet("reset");
            check("reset_ready0", 32'(req0_ready), 0);
            check("reset_ready1", 32'(req1_ready), 0);
        end
        @(negedge CLK);
        frame_start = 1'b0;  req0_done = 1'b0;  req1_done = 1'b0;  frame_complete = 1'b0;
        RESET_N = 1'b1;
        repeat (4) rand_step(1'b0, 1'b1);
        check("no_activity_busy", 32'(busy), 0);

        run_frame(30, 1'b1);
        run_frame(30, 1'b0);

        // Abort mid-frame: a write is in flight when reset hits.
        rand_step(1'b1, 1'b0);
        repeat ((CLEAR_CYCLES > 0) ? 7 : 3) rand_step(1'b0, 1'b0);
        step(1'b0, 1'b1, 16'd3, 8'h5A, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check_quiet("abort");
        model_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
        run_frame(20, 1'b1);

        repeat (3) idle_step(1'b0);
        check("queue_empty_at_end", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
